// File: rtl/window_feeder.sv
// Raster-order frame streamer: reads an NxN feature map from synchronous RAM and
// feeds the KxK line-buffer window one pixel per cycle, flagging full neighbourhoods.
module window_feeder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int K      = 5,
    parameter int W0     = 28,
    parameter int W1     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              ready,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] win_din,
    output logic              win_shift,
    output logic              win_state,
    output logic              win_valid,
    output logic [7:0]        win_row,
    output logic [7:0]        win_col,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    localparam logic [15:0] TOT0_M1 = 16'(W0 * W0 - 1);
    localparam logic [15:0] TOT1_M1 = 16'(W1 * W1 - 1);
    localparam logic [7:0]  N0_M1   = 8'(W0 - 1);
    localparam logic [7:0]  N1_M1   = 8'(W1 - 1);
    localparam logic [7:0]  EDGE    = 8'(K - 1);

    state_t      state;
    logic [15:0] idx;
    logic [15:0] tot_m1;
    logic [7:0]  n_m1;
    logic [7:0]  row, col;

    assign tot_m1 = win_state ? TOT1_M1 : TOT0_M1;
    assign n_m1   = win_state ? N1_M1 : N0_M1;

    // Issue follows ready combinationally so a stall costs no extra bubble.
    assign ram_re  = (state == ISSUE) && ready;
    // RAM data is forwarded straight into the window on the return cycle.
    assign win_din = win_shift ? ram_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            win_state <= 1'b0;
            ram_addr  <= '0;
            idx       <= '0;
            win_shift <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            win_shift <= ram_re;
            done      <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    win_state <= mode;
                    ram_addr  <= base_addr;
                    idx       <= '0;
                    busy      <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: if (ready) begin
                    ram_addr <= ram_addr + ADDR_W'(1);
                    idx      <= idx + 16'd1;
                    if (idx == tot_m1) state <= DRAIN;
                end
                // Hold until the last pixel's valid flag has been presented.
                DRAIN: if (!win_shift) begin
                    done  <= 1'b1;
                    state <= FIN;
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= '0;
            col       <= '0;
            win_row   <= '0;
            win_col   <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= win_shift && (row >= EDGE) && (col >= EDGE);
            if (state == IDLE && go) begin
                row <= '0;
                col <= '0;
            end else if (win_shift) begin
                win_row <= row;
                win_col <= col;
                if (col == n_m1) begin
                    col <= '0;
                    row <= row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_feeder.sv
// Randomized bench for window_feeder: RAM model plus an index-based reference
// of pixel order, neighbourhood positions and frame timing.
module tb_window_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        mode = 1'b0;
    logic [9:0]  base_addr = '0;
    logic        ready = 1'b1;
    logic        ram_re;
    logic [9:0]  ram_addr;
    logic [31:0] ram_rdata = '0;
    logic [31:0] win_din;
    logic        win_shift, win_state, win_valid, busy, done;
    logic [7:0]  win_row, win_col;

    window_feeder dut (
        .clk(clk), .rst_n(rst_n), .go(go), .mode(mode), .base_addr(base_addr),
        .ready(ready), .ram_re(ram_re), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .win_din(win_din), .win_shift(win_shift), .win_state(win_state),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0, checks = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // per-frame reference state
    bit f_mode;
    int f_n, f_total, f_base;
    int rd_cnt, sh_cnt, vld_cnt, done_cnt, done_cyc, go_cyc, last_vld_cyc;
    bit prev_shift;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_shift) begin
                int last, r, c;
                last = sh_cnt - 1;
                r = last / f_n;
                c = last % f_n;
                chk("valid", win_valid, (r >= 4 && c >= 4));
                chk("row", win_row, r);
                chk("col", win_col, c);
            end else begin
                chk("valid_idle", win_valid, 0);
            end
            if (win_valid) begin
                vld_cnt++;
                last_vld_cyc = cyc;
            end
            if (ram_re) begin
                chk("addr", ram_addr, (f_base + rd_cnt) % 1024);
                chk("busy", busy, 1);
                rd_cnt++;
            end
            if (win_shift) begin
                chk("din", win_din, mem[(f_base + sh_cnt) % 1024]);
                chk("state", win_state, f_mode);
                sh_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_pos", cyc - last_vld_cyc, 1);
                chk("done_pix", sh_cnt, f_total);
            end
            prev_shift = win_shift;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after done.
    task automatic run_frame(input bit m, input int b, input bit stall, input bit mid_go,
                             input int rst_at, input bit seq);
        bit aborted = 0;
        int c;
        for (int a = 0; a < 1024; a++) mem[a] = seq ? 32'(a) : $urandom;
        f_mode = m; f_n = m ? 12 : 28; f_total = f_n * f_n; f_base = b;
        rd_cnt = 0; sh_cnt = 0; vld_cnt = 0; done_cnt = 0; prev_shift = 0;
        chk("busy_idle", busy, 0);
        mode = m; base_addr = 10'(b); go = 1'b1; ready = 1'b1; go_cyc = cyc;
        @(posedge clk); #1;
        go = 1'b0; mode = ~m; base_addr = 10'($urandom);
        c = 1;
        while (done_cnt == 0 && c < 4000 && !aborted) begin
            ready = stall ? ((c % 50) < 40) : 1'b1;
            go = mid_go && (c == 100);
            if (mid_go) mode = 1'b1;
            if (rst_at >= 0 && sh_cnt >= rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_out", {ram_re, ram_addr, win_din, win_shift, win_state, win_valid,
                                win_row, win_col, busy, done}, 64'd0);
                @(posedge clk); #1;
                rst_n = 1'b1; prev_shift = 0; go = 1'b0; ready = 1'b1;
                @(posedge clk); #1;
                aborted = 1;
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        go = 1'b0; ready = 1'b1;
        if (!aborted) begin
            chk("rd_cnt", rd_cnt, f_total);
            chk("sh_cnt", sh_cnt, f_total);
            chk("vld_cnt", vld_cnt, (f_n - 4) * (f_n - 4));
            chk("done_cnt", done_cnt, 1);
            if (!stall) chk("done_lat", done_cyc - go_cyc, f_total + 3);
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = 32'(a);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_init", {ram_re, ram_addr, win_din, win_shift, win_state, win_valid,
                         win_row, win_col, busy, done}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 0,   0, 0, -1, 1);   // sequential data, baseline
        run_frame(1, 100, 0, 0, -1, 0);   // small frame, offset base
        run_frame(0, 0,   1, 0, -1, 0);   // periodic ready stalls
        run_frame(0, 900, 0, 0, -1, 0);   // address wrap
        run_frame(0, int'($urandom_range(0, 1023)), 0, 1, -1, 0);  // stray go mid-frame
        run_frame(0, 0,   0, 0, 300, 0);  // async reset mid-frame
        run_frame(0, 0,   0, 0, -1, 0);   // clean frame after reset
        for (int k = 0; k < 3; k++)
            run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                      1'($urandom_range(0, 1)), 0, -1, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
